// File: rtl/mms_if.sv
// mms_if: sample/result bundle between the inverse-Park/Clarke stage, mms_pipe and the PWM comparators
// Ports (signals):
//   in_valid, mode[1:0], UA/UB/UC[N-1:0]        upstream sample, sign-magnitude QN.Q
//   out_valid, outUA/outUB/outUC[N-1:0], sat_flag  modulated result
// Modports: master drives the sample and observes the result; slave is the pipeline.
interface mms_if #(parameter int N = 24);
    logic         in_valid;
    logic [1:0]   mode;
    logic [N-1:0] UA, UB, UC;
    logic         out_valid;
    logic [N-1:0] outUA, outUB, outUC;
    logic         sat_flag;
    modport master (output in_valid, mode, UA, UB, UC, input out_valid, outUA, outUB, outUC, sat_flag);
    modport slave  (input in_valid, mode, UA, UB, UC, output out_valid, outUA, outUB, outUC, sat_flag);
endinterface

// File: rtl/mms_pipe.sv
// mms_pipe: 4-stage pipelined three-phase min-max zero-sequence injection (scale, extremes, offset, apply)
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset, flushes every stage
//   bus        mms_if.slave: in_valid/mode/UA/UB/UC in, out_valid/outUA/outUB/outUC/sat_flag out
// Optional feature macro: MMS_SAT_EN (limit outputs to +/-LIM and report sat_flag)
// Internally samples are two's complement with two extra bits so max+min and scaled+off never wrap.
module mms_pipe #(
    parameter int           N   = 24,
    parameter int           Q   = 12,
    parameter logic [N-1:0] K   = 24'h001279,
    parameter logic [N-1:0] LIM = 24'h001000
) (
    input logic clk,
    input logic rst,
    mms_if.slave bus
);
    localparam int W = N + 2;
    localparam logic [N-2:0] KM = K[N-2:0];
    localparam logic signed [W-1:0] LIMS = W'(LIM[N-2:0]);

    // |x|*|K| >> Q, saturated to N-1 bits; a zero magnitude comes out as +0 automatically
    function automatic logic signed [W-1:0] scale(input logic [N-1:0] x);
        logic [2*N-3:0] p;
        logic [W-1:0]   r;
        p = ({{(N-1){1'b0}}, x[N-2:0]} * {{(N-1){1'b0}}, KM}) >> Q;
        r = {{(W-N+1){1'b0}}, (|p[2*N-3:N-1]) ? {(N-1){1'b1}} : p[N-2:0]};
        return (x[N-1] ^ K[N-1]) ? -r : r;
    endfunction

    // back to sign-magnitude; returns {sat, sign, magnitude}
    function automatic logic [N:0] to_out(input logic signed [W-1:0] s);
        logic [W-1:0]   a;
        logic [N-2:0]   m;
        logic           sat;
        a = s[W-1] ? -s : s;
`ifdef MMS_SAT_EN
        sat = a > W'(LIM[N-2:0]);
        m = sat ? LIM[N-2:0] : a[N-2:0];
`else
        sat = 1'b0;
        m = a[N-2:0];
`endif
        return {sat, s[W-1] && m != '0, m};
    endfunction

    logic                v1, v2, v3;
    logic [1:0]          m1, m2;
    logic signed [W-1:0] a1, b1, c1, a2, b2, c2, a3, b3, c3;
    logic signed [W-1:0] mx2, mn2, off3;
    logic signed [W-1:0] mab, nab, mx, mn, sum, hlf, off0, off1, off2, off, amx, amn;
    logic [N:0]          oa, ob, oc;

    assign mab  = a1 > b1 ? a1 : b1;
    assign nab  = a1 < b1 ? a1 : b1;
    assign mx   = mab > c1 ? mab : c1;
    assign mn   = nab < c1 ? nab : c1;
    assign sum  = mx2 + mn2;
    assign hlf  = (sum < 0 ? -sum : sum) >>> 1;
    assign off0 = sum < 0 ? hlf : -hlf;
    assign off1 = LIMS - mx2;
    assign off2 = -LIMS - mn2;
    assign amx  = mx2 < 0 ? -mx2 : mx2;
    assign amn  = mn2 < 0 ? -mn2 : mn2;
    assign off  = m2 == 2'd0 ? off0 : m2 == 2'd1 ? off1 : m2 == 2'd2 ? off2 : (amx >= amn ? off1 : off2);
    assign oa   = to_out(a3 + off3);
    assign ob   = to_out(b3 + off3);
    assign oc   = to_out(c3 + off3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            v3            <= 1'b0;
            m1            <= '0;
            m2            <= '0;
            a1            <= '0;
            b1            <= '0;
            c1            <= '0;
            a2            <= '0;
            b2            <= '0;
            c2            <= '0;
            mx2           <= '0;
            mn2           <= '0;
            a3            <= '0;
            b3            <= '0;
            c3            <= '0;
            off3          <= '0;
            bus.out_valid <= 1'b0;
            bus.sat_flag  <= 1'b0;
            bus.outUA     <= '0;
            bus.outUB     <= '0;
            bus.outUC     <= '0;
        end else begin
            v1            <= bus.in_valid;
            v2            <= v1;
            v3            <= v2;
            bus.out_valid <= v3;
            bus.sat_flag  <= v3 & (oa[N] | ob[N] | oc[N]);
            if (bus.in_valid) begin
                m1 <= bus.mode;
                a1 <= scale(bus.UA);
                b1 <= scale(bus.UB);
                c1 <= scale(bus.UC);
            end
            if (v1) begin
                m2  <= m1;
                a2  <= a1;
                b2  <= b1;
                c2  <= c1;
                mx2 <= mx;
                mn2 <= mn;
            end
            if (v2) begin
                a3   <= a2;
                b3   <= b2;
                c3   <= c2;
                off3 <= off;
            end
            if (v3) begin
                bus.outUA <= oa[N-1:0];
                bus.outUB <= ob[N-1:0];
                bus.outUC <= oc[N-1:0];
            end
        end
    end
endmodule

// File: tb/tb_mms_pipe.sv
// tb_mms_pipe: directed + random stimulus for mms_pipe checked against an integer-arithmetic reference model
module tb_mms_pipe;
    typedef struct {
        int          due;
        logic [23:0] a, b, c;
        logic        s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t e;
    logic [23:0] la = '0, lb = '0, lc = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mms_if #(.N(24)) bus();
    mms_pipe dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic longint scl(input logic [23:0] x);
        longint m;
        m = longint'(x[22:0]) * 4729 / 4096;
        if (m > 8388607) m = 8388607;
        return x[23] ? -m : m;
    endfunction

    function automatic exp_t model(input logic [23:0] ua, ub, uc, input logic [1:0] md);
        exp_t        r;
        longint      s[3];
        longint      mx, mn, sm, off, v, m;
        logic [23:0] o[3];
        s[0] = scl(ua);
        s[1] = scl(ub);
        s[2] = scl(uc);
        mx = s[0];
        mn = s[0];
        for (int i = 1; i < 3; i++) begin
            if (s[i] > mx) mx = s[i];
            if (s[i] < mn) mn = s[i];
        end
        sm = mx + mn;
        case (md)
            2'd0:    off = sm < 0 ? (-sm) / 2 : -(sm / 2);
            2'd1:    off = 4096 - mx;
            2'd2:    off = -4096 - mn;
            default: off = ((mx < 0 ? -mx : mx) >= (mn < 0 ? -mn : mn)) ? 4096 - mx : -4096 - mn;
        endcase
        r.s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v = s[i] + off;
            m = v < 0 ? -v : v;
`ifdef MMS_SAT_EN
            if (m > 4096) begin
                m = 4096;
                r.s = 1'b1;
            end
`else
            m = m % 8388608;
`endif
            o[i] = {v < 0 && m != 0, m[22:0]};
        end
        r.a = o[0];
        r.b = o[1];
        r.c = o[2];
        r.due = 0;
        return r;
    endfunction

    function automatic logic [23:0] rnd();
        int          sel;
        logic [22:0] m;
        sel = $urandom_range(0, 3);
        m = sel == 0 ? 23'($urandom) : sel == 1 ? 23'(0) : 23'($urandom_range(0, 8191));
        return {1'($urandom_range(0, 1)), m};
    endfunction

    task automatic put(input logic [23:0] ua, ub, uc, input logic [1:0] md);
        bus.in_valid = 1'b1;
        bus.mode = md;
        bus.UA = ua;
        bus.UB = ub;
        bus.UC = uc;
    endtask

    task automatic sendr(input logic [23:0] ua, ub, uc, input logic [1:0] md);
        exp_t x;
        put(ua, ub, uc, md);
        x = model(ua, ub, uc, md);
        x.due = cyc + 4;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic sendk(input logic [23:0] ua, ub, uc, input logic [1:0] md,
                         input logic [23:0] ea, eb, ec, input logic es);
        exp_t x;
        put(ua, ub, uc, md);
        x.a = ea;
        x.b = eb;
        x.c = ec;
        x.s = es;
        x.due = cyc + 4;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.mode = 2'($urandom_range(0, 3));
        bus.UA = rnd();
        bus.UB = rnd();
        bus.UC = rnd();
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            assert ({bus.out_valid, bus.sat_flag, bus.outUA, bus.outUB, bus.outUC} === '0)
            else begin
                errors++;
                $error("FAIL reset_state got=%b %b %h %h %h exp=0", bus.out_valid, bus.sat_flag, bus.outUA, bus.outUB, bus.outUC);
            end
            q.delete();
            la = '0;
            lb = '0;
            lc = '0;
        end else if (bus.out_valid) begin
            checks++;
            assert (q.size() > 0)
            else begin
                errors++;
                $error("FAIL unexpected_valid cyc=%0d got=1 exp=0", cyc);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                assert (cyc === e.due)
                else begin
                    errors++;
                    $error("FAIL latency got=%0d exp=%0d", cyc, e.due);
                end
                checks++;
                assert ({bus.outUA, bus.outUB, bus.outUC, bus.sat_flag} === {e.a, e.b, e.c, e.s})
                else begin
                    errors++;
                    $error("FAIL data cyc=%0d got=%h %h %h sat=%b exp=%h %h %h sat=%b", cyc, bus.outUA, bus.outUB, bus.outUC, bus.sat_flag, e.a, e.b, e.c, e.s);
                end
                la = e.a;
                lb = e.b;
                lc = e.c;
            end
        end else begin
            checks++;
            assert ({bus.sat_flag, bus.outUA, bus.outUB, bus.outUC} === {1'b0, la, lb, lc})
            else begin
                errors++;
                $error("FAIL hold cyc=%0d got=%b %h %h %h exp=0 %h %h %h", cyc, bus.sat_flag, bus.outUA, bus.outUB, bus.outUC, la, lb, lc);
            end
            if (q.size() > 0) begin
                checks++;
                assert (q[0].due >= cyc)
                else begin
                    errors++;
                    $error("FAIL missing_valid got=0 exp=1 due=%0d", q[0].due);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.mode = '0;
        bus.UA = '0;
        bus.UB = '0;
        bus.UC = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        sendk(24'h000800, 24'h800400, 24'h800400, 2'd0, 24'h0006ED, 24'h8006ED, 24'h8006ED, 1'b0);
        sendk(24'h000800, 24'h800400, 24'h800400, 2'd1, 24'h001000, 24'h000226, 24'h000226, 1'b0);
        sendk(24'h000800, 24'h800400, 24'h800400, 2'd2, 24'h800226, 24'h801000, 24'h801000, 1'b0);
        sendk(24'h000800, 24'h800400, 24'h800400, 2'd3, 24'h001000, 24'h000226, 24'h000226, 1'b0);
`ifdef MMS_SAT_EN
        sendk(24'h004000, 24'h800000, 24'h804000, 2'd0, 24'h001000, 24'h000000, 24'h801000, 1'b1);
`else
        sendk(24'h004000, 24'h800000, 24'h804000, 2'd0, 24'h0049E4, 24'h000000, 24'h8049E4, 1'b0);
`endif
        idle(6);
        for (int i = 0; i < 8; i++) sendr(rnd(), rnd(), rnd(), 2'(i));
        idle(6);
        repeat (3) sendr(rnd(), rnd(), rnd(), 2'($urandom_range(0, 3)));
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sendr(24'h000800, 24'h800400, 24'h800400, 2'd3);
        idle(8);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) sendr(rnd(), rnd(), rnd(), 2'($urandom_range(0, 3)));
            else idle(1);
        end
        idle(8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
